// File: rtl/mm_pkg.sv
// Shared constants for the systolic matrix-multiply block: register map,
// control/status bit positions, run-state encoding and the run length.
package mm_pkg;

   // Region base offsets expressed as word indices (byte offset / 4).
   localparam logic [7:0] OFF_CTRL = 8'h00;
   localparam logic [7:0] OFF_A    = 8'h40;
   localparam logic [7:0] OFF_B    = 8'h80;
   localparam logic [7:0] OFF_C    = 8'hC0;

   localparam int CTRL_START = 0;
   localparam int CTRL_CLEAR = 1;
   localparam int STAT_BUSY  = 0;
   localparam int STAT_DONE  = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_e;

   // Number of clock steps in one run; the last step index is one less.
   function automatic int step_count(input int n);
      return 3 * n - 1;
   endfunction

endpackage

// File: rtl/mm_pe.sv
// Output-stationary multiply-accumulate cell: forwards a to the right and
// b downward through registers while accumulating a*b.
module mm_pe #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear_i,
   input  logic                     en_i,
   input  logic signed [DATA_W-1:0] a_i,
   input  logic signed [DATA_W-1:0] b_i,
   output logic signed [DATA_W-1:0] a_o,
   output logic signed [DATA_W-1:0] b_o,
   output logic signed [ACC_W-1:0]  acc_o
);

   logic signed [DATA_W-1:0]   a_q;
   logic signed [DATA_W-1:0]   b_q;
   logic signed [ACC_W-1:0]    acc_q;
   logic signed [2*DATA_W-1:0] prod;

   assign prod = a_i * b_i;

   // NOTE: clocked state uses non-blocking assignments so every cell samples
   // its neighbour's value from before the edge, which is what makes the skew work.
   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else if (en_i) begin
         a_q   <= a_i;
         b_q   <= b_i;
         acc_q <= acc_q + ACC_W'(prod);
      end
   end

   assign a_o   = a_q;
   assign b_o   = b_q;
   assign acc_o = acc_q;

endmodule

// File: rtl/mm_systolic_array.sv
// Bus-mapped NxN signed matrix multiplier: operand register file, skewed
// feed into an output-stationary PE grid, run sequencer and read mux.
module mm_systolic_array
   import mm_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  wen,
   input  logic [21:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);

   localparam int STEP_W    = $clog2(3 * N);
   localparam int IDX_W     = $clog2(N);
   localparam int LAST_STEP = step_count(N) - 1;

   logic signed [DATA_W-1:0] a_q [N][N];
   logic signed [DATA_W-1:0] b_q [N][N];
   run_state_e               state_q;
   logic                     done_q;
   logic [STEP_W-1:0]        step_q;
   logic                     busy;

   logic       in_range, wr, ctrl_wr, start_fire, clear_fire, a_wr, b_wr;
   logic [5:0] widx;

   assign busy       = (state_q == ST_RUN);
   assign in_range   = (addr[21:8] == '0);
   assign wr         = in_range && wen[0];
   assign widx       = addr[5:0];
   assign ctrl_wr    = wr && (addr[7:0] == OFF_CTRL);
   assign start_fire = ctrl_wr && wdata[CTRL_START] && !busy;
   assign clear_fire = ctrl_wr && wdata[CTRL_CLEAR] && !busy;
   assign a_wr       = wr && !busy && (addr[7:6] == OFF_A[7:6]);
   assign b_wr       = wr && !busy && (addr[7:6] == OFF_B[7:6]);

   // NOTE: the operand arrays are reset explicitly because software may read
   // them back before writing, and reset must present an all-zero register map.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
               a_q[i][k] <= '0;
               b_q[i][k] <= '0;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
               if (a_wr && widx == 6'(i * N + k)) a_q[i][k] <= wdata[DATA_W-1:0];
               if (b_wr && widx == 6'(i * N + k)) b_q[i][k] <= wdata[DATA_W-1:0];
            end
         end
      end
   end

   // Start wins over clear; a clear while running is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
         step_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_fire) begin
                  state_q <= ST_RUN;
                  done_q  <= 1'b0;
                  step_q  <= '0;
               end else if (clear_fire) begin
                  done_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (step_q == STEP_W'(LAST_STEP)) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end else begin
                  step_q  <= step_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   logic signed [DATA_W-1:0] a_feed [N];
   logic signed [DATA_W-1:0] b_feed [N];
   logic signed [DATA_W-1:0] a_link [N][N+1];
   logic signed [DATA_W-1:0] b_link [N+1][N];
   logic signed [ACC_W-1:0]  c_w    [N][N];
   logic [N-1:0]             unused_edge;
   logic                     unused_bus;

   assign unused_bus = ^{wen[3:1], wdata[31:DATA_W]};

   // Row/column g is delayed by g steps so matching k indices meet in each PE.
   for (genvar g = 0; g < N; g++) begin : g_feed
      logic [STEP_W-1:0] diff;
      logic              live;
      assign diff = step_q - STEP_W'(g);
      assign live = busy && (step_q >= STEP_W'(g)) && (diff < STEP_W'(N));
      assign a_feed[g]      = live ? a_q[g][diff[IDX_W-1:0]] : '0;
      assign b_feed[g]      = live ? b_q[diff[IDX_W-1:0]][g] : '0;
      assign a_link[g][0]   = a_feed[g];
      assign b_link[0][g]   = b_feed[g];
      assign unused_edge[g] = ^{a_link[g][N], b_link[N][g]};
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         mm_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
         ) u_pe (
            .clk     (clk),
            .reset   (reset),
            .clear_i (start_fire),
            .en_i    (busy),
            .a_i     (a_link[i][j]),
            .b_i     (b_link[i][j]),
            .a_o     (a_link[i][j+1]),
            .b_o     (b_link[i+1][j]),
            .acc_o   (c_w[i][j])
         );
      end
   end

   // NOTE: rdata gets a default before the case so unmatched addresses read 0
   // and no latch is inferred.
   always_comb begin
      rdata = '0;
      if (in_range) begin
         case (addr[7:6])
            OFF_CTRL[7:6]: begin
               if (widx == 6'd0) begin
                  rdata[STAT_BUSY] = busy;
                  rdata[STAT_DONE] = done_q;
               end
            end
            OFF_A[7:6]: begin
               for (int i = 0; i < N; i++)
                  for (int k = 0; k < N; k++)
                     if (widx == 6'(i * N + k)) rdata = 32'(a_q[i][k]);
            end
            OFF_B[7:6]: begin
               for (int i = 0; i < N; i++)
                  for (int k = 0; k < N; k++)
                     if (widx == 6'(i * N + k)) rdata = 32'(b_q[i][k]);
            end
            default: begin
               for (int i = 0; i < N; i++)
                  for (int j = 0; j < N; j++)
                     if (widx == 6'(i * N + j)) rdata = 32'(c_w[i][j]);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mm_systolic_array.sv
// Directed bench for mm_systolic_array: register map, result scenarios,
// run latency, busy-time write rejection, clear and mid-run reset.
module tb_mm_systolic_array;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  wen;
   logic [21:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   int checks = 0;
   int errors = 0;

   mm_systolic_array #(.N(N), .DATA_W(8), .ACC_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .wen   (wen),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] c00;
      logic [31:0] c30;
      logic [31:0] c33;
   } scen_t;

   scen_t scen [4];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
      end
   endtask

   task automatic bus_write(input logic [21:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      wen   = 4'hF;
      @(posedge clk);
      #1;
      wen   = 4'h0;
   endtask

   task automatic bus_read(input logic [21:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a;
      wen  = 4'h0;
      #1;
      d = rdata;
   endtask

   function automatic int a_elem(input int kind, input int i, input int k);
      case (kind)
         0:       return (i == k) ? 1 : 0;
         1:       return i + k + 1;
         2:       return -128;
         default: return 127;
      endcase
   endfunction

   function automatic int b_elem(input int kind, input int k, input int j);
      case (kind)
         0:       return k * 4 + j;
         1:       return 2;
         2:       return -128;
         default: return -1;
      endcase
   endfunction

   function automatic logic [31:0] model_c(input int kind, input int i, input int j);
      int acc = 0;
      for (int k = 0; k < N; k++) acc += a_elem(kind, i, k) * b_elem(kind, k, j);
      return 32'(acc);
   endfunction

   task automatic load(input int kind);
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            bus_write(22'(32'h40 + i * N + k), 32'(a_elem(kind, i, k)));
            bus_write(22'(32'h80 + i * N + k), 32'(b_elem(kind, i, k)));
         end
   endtask

   // Polls STATUS just after each edge; edge numbers count from the start write.
   task automatic wait_done(input int first_e, output int done_e, output int busy_cnt);
      addr     = '0;
      wen      = 4'h0;
      done_e   = 0;
      busy_cnt = 0;
      for (int e = first_e; e <= 60; e++) begin
         @(posedge clk);
         #1;
         if (rdata[0]) busy_cnt++;
         if (rdata[1]) begin
            done_e = e;
            break;
         end
      end
   endtask

   task automatic check_all_c(input string tag, input int kind);
      logic [31:0] d;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            bus_read(22'(32'hC0 + i * N + j), d);
            check($sformatf("%s_c%0d%0d", tag, i, j), d, model_c(kind, i, j));
         end
   endtask

   initial begin
      logic [31:0] d;
      int          de;
      int          bc;

      reset = 1'b1;
      wen   = 4'h0;
      addr  = '0;
      wdata = '0;

      scen[0] = '{"ident",   0, 32'd0,        32'd12,       32'd15};
      scen[1] = '{"ipk_x2",  1, 32'd20,       32'd44,       32'd44};
      scen[2] = '{"neg128",  2, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
      scen[3] = '{"127xm1",  3, 32'hFFFF_FE04, 32'hFFFF_FE04, 32'hFFFF_FE04};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      bus_read(22'h000, d); check("rst_status", d, 32'h0);
      bus_read(22'h040, d); check("rst_a00", d, 32'h0);
      bus_read(22'h0CF, d); check("rst_c33", d, 32'h0);

      bus_write(22'h140, 32'h5);
      bus_write(22'h100, 32'h1);
      bus_read(22'h140, d); check("oor_read", d, 32'h0);
      bus_read(22'h040, d); check("oor_a00", d, 32'h0);
      bus_read(22'h000, d); check("oor_status", d, 32'h0);

      for (int s = 0; s < 4; s++) begin
         load(scen[s].kind);
         bus_write(22'h000, 32'h1);
         wait_done(1, de, bc);
         check({scen[s].name, "_done_edge"}, 32'(de), 32'd11);
         if (s == 0) check("busy_cycles", 32'(bc), 32'd10);
         check_all_c(scen[s].name, scen[s].kind);
         bus_read(22'h0C0, d); check({scen[s].name, "_hand_c00"}, d, scen[s].c00);
         bus_read(22'h0CC, d); check({scen[s].name, "_hand_c30"}, d, scen[s].c30);
         bus_read(22'h0CF, d); check({scen[s].name, "_hand_c33"}, d, scen[s].c33);
      end

      bus_write(22'h040, 32'h80);
      bus_read(22'h040, d); check("a_sext", d, 32'hFFFF_FF80);
      bus_write(22'h081, 32'h7F);
      bus_read(22'h081, d); check("b_pos", d, 32'h0000_007F);

      load(1);
      bus_write(22'h000, 32'h1);
      bus_write(22'h000, 32'h1);
      bus_write(22'h040, 32'd99);
      bus_write(22'h000, 32'h2);
      wait_done(4, de, bc);
      check("busy_done_edge", 32'(de), 32'd11);
      check_all_c("busy", 1);
      bus_read(22'h040, d); check("busy_a00_kept", d, 32'd1);
      bus_read(22'h000, d); check("busy_status", d, 32'h2);

      bus_write(22'h000, 32'h2);
      bus_read(22'h000, d); check("clr_status", d, 32'h0);
      bus_read(22'h0CC, d); check("clr_c30", d, 32'd44);

      bus_write(22'h000, 32'h1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      bus_read(22'h000, d); check("abort_status", d, 32'h0);
      bus_read(22'h0CC, d); check("abort_c30", d, 32'h0);
      bus_read(22'h0CF, d); check("abort_c33", d, 32'h0);
      bus_read(22'h040, d); check("abort_a00", d, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
